// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 line writer: FSM states and LCD byte codes.
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_CHAR = 2'd2,
      ST_DONE = 2'd3
   } lcd_state_t;

   localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] LCD_CHAR_SPACE    = 8'h20;
   localparam logic [6:0] LCD_CHAR_NULL     = 7'h00;

   // Wide enough to index the 16-character maximum line.
   localparam int IDX_W = 4;

endpackage

// File: rtl/lcd_char_sel.sv
// Combinational character picker: selects char[idx] from the packed line and maps NUL to space.
module lcd_char_sel
   import lcd_pkg::*;
#(
   parameter int NCHAR = 11,
   parameter int CW    = 7
) (
   input  logic [NCHAR*CW-1:0] i_line,
   input  logic [IDX_W-1:0]    i_idx,
   output logic [7:0]          o_byte
);

   logic [CW-1:0] w_char;

   always_comb begin
      w_char = '0;
      // Char 0 sits in the MSBs of the packed line.
      for (int k = 0; k < NCHAR; k++) begin
         if (i_idx == IDX_W'(k)) w_char = i_line[(NCHAR-k)*CW-1 -: CW];
      end
      if (w_char == LCD_CHAR_NULL) o_byte = LCD_CHAR_SPACE;
      else                         o_byte = 8'(w_char);
   end

endmodule

// File: rtl/lcd_line_writer.sv
// Streams one packed ASCII line to the HD44780 byte bus: a set-DDRAM-address command, then one data byte per char.
// Optional feature LCD_LINE_CACHE_EN: a start repeating the last fully written {row,line} completes without bytes.
module lcd_line_writer
   import lcd_pkg::*;
#(
   parameter int         NCHAR   = 11,
   parameter int         CW      = 7,
   parameter logic [7:0] ROW_OFS = 8'h40
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic                row_i,
   input  logic [NCHAR*CW-1:0] line_i,
   output logic                lcd_valid_o,
   output logic                lcd_rs_o,
   output logic [7:0]          lcd_dat_o,
   input  logic                lcd_ready_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [1:0]          dbg_state_o
);

   // Handshake: a byte transfers on a rising edge where lcd_valid_o & lcd_ready_i; while valid is
   // high and ready low, rs/dat hold steady and valid cannot drop.

   lcd_state_t          r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_idx, w_idx_nxt;
   logic                r_row;
   logic [NCHAR*CW-1:0] r_line;
   logic                w_latch;
   logic                w_hit;
   logic [7:0]          w_char_byte;

   lcd_char_sel #(.NCHAR(NCHAR), .CW(CW)) u_char_sel (
      .i_line (r_line),
      .i_idx  (r_idx),
      .o_byte (w_char_byte)
   );

`ifdef LCD_LINE_CACHE_EN
   logic                r_cache_vld;
   logic                r_cache_row;
   logic [NCHAR*CW-1:0] r_cache_line;

   assign w_hit = r_cache_vld && (r_cache_row == row_i) && (r_cache_line == line_i);

   // A hit leaves the snapshot equal to the copy, so refreshing on every DONE is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cache_vld  <= 1'b0;
         r_cache_row  <= 1'b0;
         r_cache_line <= '0;
      end else if (r_state == ST_DONE) begin
         r_cache_vld  <= 1'b1;
         r_cache_row  <= r_row;
         r_cache_line <= r_line;
      end
   end
`else
   assign w_hit = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_latch     = 1'b0;
      lcd_valid_o = 1'b0;
      lcd_rs_o    = 1'b0;
      lcd_dat_o   = 8'h00;
      done_o      = 1'b0;
      busy_o      = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               w_latch     = 1'b1;
               w_state_nxt = w_hit ? ST_DONE : ST_ADDR;
            end
         end
         ST_ADDR: begin
            lcd_valid_o = 1'b1;
            lcd_dat_o   = LCD_CMD_SET_DDRAM | (r_row ? ROW_OFS : 8'h00);
            if (lcd_ready_i) begin
               w_state_nxt = ST_CHAR;
               w_idx_nxt   = '0;
            end
         end
         ST_CHAR: begin
            lcd_valid_o = 1'b1;
            lcd_rs_o    = 1'b1;
            lcd_dat_o   = w_char_byte;
            if (lcd_ready_i) begin
               if (r_idx == IDX_W'(NCHAR-1)) w_state_nxt = ST_DONE;
               else                          w_idx_nxt   = r_idx + 1'b1;
            end
         end
         ST_DONE: begin
            done_o      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_row   <= 1'b0;
         r_line  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_latch) begin
            r_row  <= row_i;
            r_line <= line_i;
         end
      end
   end

   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_lcd_line_writer.sv
// Self-checking bench for lcd_line_writer: randomized lines and ready patterns against a line-level byte model.
module tb_lcd_line_writer;

  localparam int NCHAR = 11;
  localparam int CW    = 7;
  localparam int LW    = NCHAR*CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          row_i = 1'b0;
  logic [LW-1:0] line_i = '0;
  logic          lcd_valid_o;
  logic          lcd_rs_o;
  logic [7:0]    lcd_dat_o;
  logic          lcd_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    dbg_state_o;

  lcd_line_writer #(.NCHAR(NCHAR), .CW(CW), .ROW_OFS(8'h40)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .row_i       (row_i),
    .line_i      (line_i),
    .lcd_valid_o (lcd_valid_o),
    .lcd_rs_o    (lcd_rs_o),
    .lcd_dat_o   (lcd_dat_o),
    .lcd_ready_i (lcd_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ready patterns: 0 = always high, 1 = toggling, 2 = random
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       lcd_ready_i = 1'b1;
      1:       lcd_ready_i = ~lcd_ready_i;
      default: lcd_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard: {rs, dat} per byte in send order
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int         acc_cnt  = 0;
  int         done_cnt = 0;
  logic       held     = 1'b0;
  logic [9:0] held_val = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) check("hold_stable", 32'({lcd_valid_o, lcd_rs_o, lcd_dat_o}), 32'(held_val));
      if (lcd_valid_o && lcd_ready_i) begin
        acc_cnt++;
        if (exp_q.size() == 0) check("extra_byte", 32'(1), 32'(0));
        else begin
          exp_v = exp_q.pop_front();
          check("byte", 32'({lcd_rs_o, lcd_dat_o}), 32'(exp_v));
        end
      end
      held     = lcd_valid_o && !lcd_ready_i;
      held_val = {1'b1, lcd_rs_o, lcd_dat_o};
      if (done_o) done_cnt++;
    end
  end

  // reference model
`ifdef LCD_LINE_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  logic          m_cache_vld  = 1'b0;
  logic          m_cache_row  = 1'b0;
  logic [LW-1:0] m_cache_line = '0;

  function automatic logic [CW-1:0] char_at(input logic [LW-1:0] line, input int k);
    return line[(NCHAR-k)*CW-1 -: CW];
  endfunction

  function automatic void push_expected(input logic row, input logic [LW-1:0] line);
    logic [CW-1:0] c;
    exp_q.push_back({1'b0, (row ? 8'hC0 : 8'h80)});
    for (int k = 0; k < NCHAR; k++) begin
      c = char_at(line, k);
      exp_q.push_back({1'b1, (c == '0) ? 8'h20 : {1'b0, c}});
    end
  endfunction

  function automatic logic [LW-1:0] pack_str(input string s);
    logic [LW-1:0] l;
    byte b;
    l = '0;
    for (int k = 0; k < NCHAR; k++) begin
      b = s.getc(k);
      l[(NCHAR-k)*CW-1 -: CW] = b[6:0];
    end
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NCHAR; k++)
      l[(NCHAR-k)*CW-1 -: CW] = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(32, 126));
    return l;
  endfunction

  // driver: write one line, optionally pulsing start again at cycle mid_evt
  task automatic run_line(input logic row, input logic [LW-1:0] line, input int mode, input int mid_evt);
    int   c;
    int   done_base;
    logic skip;
    rmode     = mode;
    skip      = CACHE_EN && m_cache_vld && (m_cache_row == row) && (m_cache_line == line);
    if (!skip) push_expected(row, line);
    done_base = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    row_i   = row;
    line_i  = line;
    @(negedge clk);
    start_i = 1'b0;
    line_i  = rand_line();
    row_i   = 1'($urandom_range(0, 1));
    c = 1;
    check("busy_on", 32'(busy_o), 32'(1));
    check("first_valid", 32'(lcd_valid_o), skip ? 32'(0) : 32'(1));
    while (!done_o && c < 400) begin
      if (c == mid_evt) begin
        start_i = 1'b1;
        line_i  = rand_line();
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    start_i = 1'b0;
    if (!done_o) begin
      check("done_timeout", 32'(0), 32'(1));
    end else begin
      if (mode == 0) check("done_latency", 32'(c), skip ? 32'(1) : 32'(NCHAR+2));
      check("busy_at_done", 32'(busy_o), 32'(1));
      check("valid_at_done", 32'(lcd_valid_o), 32'(0));
    end
    @(negedge clk);
    check("done_pulse_end", 32'(done_o), 32'(0));
    check("busy_off", 32'(busy_o), 32'(0));
    check("done_count", 32'(done_cnt - done_base), 32'(1));
    check("leftover_bytes", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    if (!skip) begin
      m_cache_vld  = 1'b1;
      m_cache_row  = row;
      m_cache_line = line;
    end
  endtask

  logic [LW-1:0] tot_line;
  logic [LW-1:0] nul_line;

  initial begin
    int c;
    int base;
    int dbase;
    tot_line = pack_str("TOT:512.34$");
    nul_line = pack_str("ABCDEFGHIJK");
    for (int k = 1; k <= 4; k++) nul_line[(NCHAR-k)*CW-1 -: CW] = 7'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(lcd_valid_o), 32'(0));
    check("rst_rs", 32'(lcd_rs_o), 32'(0));
    check("rst_dat", 32'(lcd_dat_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_done", 32'(done_o), 32'(0));
    check("rst_state", 32'(dbg_state_o), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_line(1'b0, tot_line, 0, -1);
    run_line(1'b1, tot_line, 1, -1);
    run_line(1'b0, nul_line, 2, -1);

    // start during CHAR is ignored and not queued
    run_line(1'b1, rand_line(), 0, 5);
    dbase = done_cnt;
    repeat (4) begin
      @(negedge clk);
      check("no_queued_start", 32'(lcd_valid_o), 32'(0));
    end
    check("no_extra_done", 32'(done_cnt - dbase), 32'(0));

    // async reset after the 5th byte
    rmode = 0;
    push_expected(1'b0, tot_line);
    base = acc_cnt;
    @(negedge clk);
    start_i = 1'b1; row_i = 1'b0; line_i = tot_line;
    @(negedge clk);
    start_i = 1'b0;
    c = 0;
    while (acc_cnt < base + 5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rst_wait_5", 32'(acc_cnt - base), 32'(5));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(lcd_valid_o), 32'(0));
    check("arst_rs", 32'(lcd_rs_o), 32'(0));
    check("arst_dat", 32'(lcd_dat_o), 32'(0));
    check("arst_busy", 32'(busy_o), 32'(0));
    check("arst_state", 32'(dbg_state_o), 32'(0));
    exp_q.delete();
    m_cache_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_line(1'b0, tot_line, 0, -1);

    // repeat of an identical line, then a changed one
    run_line(1'b0, tot_line, 0, -1);
    run_line(1'b1, tot_line, 0, -1);

    for (int i = 0; i < 8; i++)
      run_line(1'($urandom_range(0, 1)), rand_line(), int'($urandom_range(0, 2)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
